// File: rtl/conv_engine.sv
// conv_engine: K x K convolution of one image window per lane, LANES output
// pixels computed side by side.
//
// A run is started from IDLE. Unless the stored kernel is reused, the kernel
// is first fetched from the kernel memory into K*K registers (KER). The window
// pixels are then fetched for all lanes in parallel (WIN) and multiply-
// accumulated. Each lane result is shifted and saturated (POST), then
// presented on the result port until it is accepted (OUT).
//
// Ports
//   i_clk, i_rst        clock; asynchronous active-high reset
//   i_start             start request, sampled only in IDLE
//   i_reuse_ker         1: skip the kernel fetch and use the stored kernel
//   i_relu              1: saturate to [0, 2^DATA_W-1], 0: to the signed range
//   i_stride            address distance between neighbouring lanes
//   i_shift             arithmetic right shift applied to each sum
//   i_src_base          address of the window's top-left pixel (lane 0)
//   i_ker_base          address of kernel element 0
//   o_ker_rd/o_ker_addr kernel read request, i_ker_data one cycle later
//   o_src_rd/o_src_addr pixel read request (one 10-bit address per lane),
//                       i_src_data one cycle later
//   o_valid/i_ready     result handshake: o_data is held stable while o_valid
//                       is high and is consumed in the cycle where both are 1
//   o_data              lane l at bits [l*DATA_W +: DATA_W]
//   o_busy              high in every state except IDLE
//   o_done              one-cycle pulse in the IDLE cycle after the handshake
module conv_engine #(
  parameter int DATA_W = 8,
  parameter int K      = 3,
  parameter int IMG_W  = 28,
  parameter int LANES  = 2,
  parameter int ACC_W  = 2*DATA_W + $clog2(K*K) + 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic                    i_reuse_ker,
  input  logic                    i_relu,
  input  logic [2:0]              i_stride,
  input  logic [3:0]              i_shift,
  input  logic [9:0]              i_src_base,
  input  logic [9:0]              i_ker_base,
  output logic                    o_ker_rd,
  output logic [9:0]              o_ker_addr,
  input  logic [DATA_W-1:0]       i_ker_data,
  output logic                    o_src_rd,
  output logic [LANES*10-1:0]     o_src_addr,
  input  logic [LANES*DATA_W-1:0] i_src_data,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [LANES*DATA_W-1:0] o_data,
  output logic                    o_busy,
  output logic                    o_done
);

  localparam int KK    = K * K;
  localparam int AW    = 10;
  localparam int CNT_W = $clog2(KK + 1);
  localparam int IDX_W = $clog2(KK);
  localparam int COL_W = $clog2(K);

  // Saturation limits expressed at accumulator width.
  localparam logic signed [ACC_W-1:0] S_MAX = ACC_W'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] S_MIN = -S_MAX - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] U_MAX = ACC_W'((2 ** DATA_W) - 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_KER  = 3'd1,
    ST_WIN  = 3'd2,
    ST_POST = 3'd3,
    ST_OUT  = 3'd4
  } state_t;

  state_t state;
  state_t next_state;

  // Run parameters latched at start.
  logic [AW-1:0] src_base;
  logic [AW-1:0] ker_base;
  logic [2:0]    stride;
  logic [3:0]    shift;
  logic          relu;

  // cnt walks the kernel/window index. In WIN it runs one step past the
  // last issue so the final pixel read can be captured before POST.
  logic [CNT_W-1:0] cnt;
  logic [COL_W-1:0] col;
  logic [AW-1:0]    row_off;

  // One-cycle-delayed view of the read strobes: the returning data belongs
  // to the index that was issued in the previous cycle. Kernel and pixel
  // captures never overlap, so one index register serves both.
  logic             ker_cap;
  logic             src_cap;
  logic [IDX_W-1:0] cap_idx;

  logic signed [DATA_W-1:0] kernel [KK];
  logic signed [ACC_W-1:0]  acc    [LANES];

  logic                     start_ok;
  logic                     issue;
  logic signed [DATA_W-1:0] ker_sel;
  logic signed [ACC_W-1:0]  ker_s;
  logic signed [ACC_W-1:0]  pix_s   [LANES];
  logic signed [ACC_W-1:0]  prod    [LANES];
  logic signed [ACC_W-1:0]  shifted [LANES];
  logic [LANES*DATA_W-1:0]  res;

  assign start_ok = (state == ST_IDLE) && i_start;
  assign issue    = (state == ST_WIN) && (cnt < CNT_W'(KK));

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (i_start) next_state = i_reuse_ker ? ST_WIN : ST_KER;
      ST_KER:  if (cnt == CNT_W'(KK - 1)) next_state = ST_WIN;
      ST_WIN:  if (cnt == CNT_W'(KK)) next_state = ST_POST;
      ST_POST: next_state = ST_OUT;
      ST_OUT:  if (i_ready) next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    o_busy     = (state != ST_IDLE);
    o_ker_rd   = (state == ST_KER);
    o_src_rd   = issue;
    o_valid    = (state == ST_OUT);
    o_ker_addr = ker_base + AW'(cnt);
    o_src_addr = '0;
    for (int l = 0; l < LANES; l++) begin
      o_src_addr[l*AW +: AW] = src_base + row_off + AW'(col)
                               + AW'(l) * AW'(stride);
    end
  end

  // ------------------------------------------------- run control / counters
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      src_base <= '0;
      ker_base <= '0;
      stride   <= '0;
      shift    <= '0;
      relu     <= 1'b0;
      cnt      <= '0;
      col      <= '0;
      row_off  <= '0;
    end else if (start_ok) begin
      src_base <= i_src_base;
      ker_base <= i_ker_base;
      stride   <= i_stride;
      shift    <= i_shift;
      relu     <= i_relu;
      cnt      <= '0;
      col      <= '0;
      row_off  <= '0;
    end else begin
      case (state)
        ST_KER: begin
          cnt <= (cnt == CNT_W'(KK - 1)) ? '0 : cnt + CNT_W'(1);
        end
        ST_WIN: begin
          cnt <= (cnt == CNT_W'(KK)) ? '0 : cnt + CNT_W'(1);
          if (issue) begin
            if (col == COL_W'(K - 1)) begin
              col     <= '0;
              row_off <= row_off + AW'(IMG_W);
            end else begin
              col <= col + COL_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // ------------------------------------------------------- capture pipeline
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ker_cap <= 1'b0;
      src_cap <= 1'b0;
      cap_idx <= '0;
    end else begin
      ker_cap <= o_ker_rd;
      src_cap <= o_src_rd;
      cap_idx <= IDX_W'(cnt);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < KK; i++) kernel[i] <= '0;
    end else if (ker_cap) begin
      kernel[cap_idx] <= i_ker_data;
    end
  end

  // Unsigned pixel times signed kernel: the pixel is zero-extended and the
  // kernel sign-extended to accumulator width before a signed multiply.
  always_comb begin
    ker_sel = kernel[cap_idx];
    ker_s   = ACC_W'(ker_sel);
    for (int l = 0; l < LANES; l++) begin
      pix_s[l] = ACC_W'(i_src_data[l*DATA_W +: DATA_W]);
      prod[l]  = pix_s[l] * ker_s;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int l = 0; l < LANES; l++) acc[l] <= '0;
    end else if (start_ok) begin
      for (int l = 0; l < LANES; l++) acc[l] <= '0;
    end else if (src_cap) begin
      for (int l = 0; l < LANES; l++) acc[l] <= acc[l] + prod[l];
    end
  end

  // ---------------------------------------------------- shift and saturate
  always_comb begin
    res = '0;
    for (int l = 0; l < LANES; l++) begin
      shifted[l] = acc[l] >>> shift;
      if (relu) begin
        if (shifted[l][ACC_W-1]) begin
          res[l*DATA_W +: DATA_W] = '0;
        end else if (shifted[l] > U_MAX) begin
          res[l*DATA_W +: DATA_W] = '1;
        end else begin
          res[l*DATA_W +: DATA_W] = shifted[l][DATA_W-1:0];
        end
      end else begin
        if (shifted[l] > S_MAX) begin
          res[l*DATA_W +: DATA_W] = S_MAX[DATA_W-1:0];
        end else if (shifted[l] < S_MIN) begin
          res[l*DATA_W +: DATA_W] = S_MIN[DATA_W-1:0];
        end else begin
          res[l*DATA_W +: DATA_W] = shifted[l][DATA_W-1:0];
        end
      end
    end
  end

  // o_data is only loaded in POST, so it stays put for the whole of OUT.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_data <= '0;
    end else if (state == ST_POST) begin
      o_data <= res;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_done <= 1'b0;
    end else begin
      o_done <= (state == ST_OUT) && i_ready;
    end
  end

endmodule

// File: tb/tb_conv_engine.sv
// Testbench for conv_engine: randomized and directed runs against a
// behavioural convolution model, with a queue-based scoreboard.
module tb_conv_engine;

  localparam int DATA_W = 8;
  localparam int K      = 3;
  localparam int IMG_W  = 28;
  localparam int LANES  = 2;
  localparam int KK     = K * K;
  localparam int OW     = LANES * DATA_W;

  // ------------------------------------------------ clock / reset / signals
  logic              clk;
  logic              rst;
  logic              start;
  logic              reuse_ker;
  logic              relu;
  logic [2:0]        stride;
  logic [3:0]        shift;
  logic [9:0]        src_base;
  logic [9:0]        ker_base;
  logic              ker_rd;
  logic [9:0]        ker_addr;
  logic [DATA_W-1:0] ker_data = '0;
  logic              src_rd;
  logic [LANES*10-1:0] src_addr;
  logic [OW-1:0]     src_data = '0;
  logic              valid;
  logic              ready;
  logic [OW-1:0]     data;
  logic              busy;
  logic              done;

  int cyc = 0;
  int checks = 0;
  int fails = 0;

  logic [OW-1:0] exp_q[$];
  int            lat_q[$];

  logic [7:0] src_mem [1024];
  logic [7:0] ker_mem [1024];
  int         mk [KK];   // kernel the DUT is expected to hold

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  conv_engine #(
    .DATA_W(DATA_W), .K(K), .IMG_W(IMG_W), .LANES(LANES)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_reuse_ker(reuse_ker),
    .i_relu(relu), .i_stride(stride), .i_shift(shift),
    .i_src_base(src_base), .i_ker_base(ker_base),
    .o_ker_rd(ker_rd), .o_ker_addr(ker_addr), .i_ker_data(ker_data),
    .o_src_rd(src_rd), .o_src_addr(src_addr), .i_src_data(src_data),
    .o_valid(valid), .i_ready(ready), .o_data(data),
    .o_busy(busy), .o_done(done)
  );

  // Memories with one cycle of read latency.
  always @(posedge clk) begin
    if (ker_rd) ker_data <= ker_mem[ker_addr];
    if (src_rd) begin
      for (int l = 0; l < LANES; l++)
        src_data[l*DATA_W +: DATA_W] <= src_mem[src_addr[l*10 +: 10]];
    end
  end

  // ------------------------------------------------------------- helpers
  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Direct convolution of the window for each lane, then shift and clamp.
  function automatic logic [OW-1:0] model(input int sb, input int st,
                                          input int sh, input bit rl);
    logic [OW-1:0] r;
    int sum, a, v;
    r = '0;
    for (int l = 0; l < LANES; l++) begin
      sum = 0;
      for (int rr = 0; rr < K; rr++)
        for (int cc = 0; cc < K; cc++) begin
          a = (sb + rr*IMG_W + cc + l*st) % 1024;
          sum += int'(src_mem[a]) * mk[rr*K + cc];
        end
      sum = sum >>> sh;
      if (rl) v = (sum < 0) ? 0 : ((sum > (1 << DATA_W) - 1) ? (1 << DATA_W) - 1 : sum);
      else    v = (sum > (1 << (DATA_W-1)) - 1) ? (1 << (DATA_W-1)) - 1 :
                  ((sum < -(1 << (DATA_W-1))) ? -(1 << (DATA_W-1)) : sum);
      r[l*DATA_W +: DATA_W] = v[DATA_W-1:0];
    end
    return r;
  endfunction

  // ------------------------------------------------------------ drivers
  task automatic do_run(input bit rz, input bit rl, input int st, input int sh,
                        input int sb, input int kb, input int hold);
    int s, n, kr;
    if (!rz)
      for (int k = 0; k < KK; k++) mk[k] = int'($signed(ker_mem[(kb + k) % 1024]));
    exp_q.push_back(model(sb, st, sh, rl));
    start = 1'b1; reuse_ker = rz; relu = rl;
    stride = 3'(st); shift = 4'(sh); src_base = 10'(sb); ker_base = 10'(kb);
    s = cyc;
    lat_q.push_back(s + (rz ? KK + 3 : 2*KK + 3));
    @(posedge clk); #1;
    // Scramble the run inputs: the DUT must use its latched copies.
    start = 1'b0; reuse_ker = 1'($urandom); relu = 1'($urandom);
    stride = 3'($urandom); shift = 4'($urandom);
    src_base = 10'($urandom); ker_base = 10'($urandom);
    n = 0; kr = 0;
    while (!valid && n < 100) begin
      if (ker_rd) kr++;
      @(posedge clk); #1;
      n++;
    end
    check("valid_timeout", valid, 1);
    check("ker_rd_count", kr, rz ? 0 : KK);
    // Hold off acceptance, poking i_start which must be ignored.
    repeat (hold) begin
      start = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    start = 1'b0; ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0;
  endtask

  task automatic do_abort(input int kb);
    int s;
    start = 1'b1; reuse_ker = 1'b0; relu = 1'b0; stride = 3'd1; shift = 4'd0;
    src_base = 10'd0; ker_base = 10'(kb);
    s = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    while (cyc < s + 15) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_ker_rd", ker_rd, 0);
    check("abort_src_rd", src_rd, 0);
    check("abort_valid", valid, 0);
    check("abort_done", done, 0);
    check("abort_data", data, 0);
    for (int k = 0; k < KK; k++) mk[k] = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // ------------------------------------------------------------- monitor
  initial begin : monitor
    logic [OW-1:0] cur;
    bit prev;
    int done_at;
    cur = '0; prev = 1'b0; done_at = -10;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (valid && !prev) begin
          if (exp_q.size() == 0) begin
            check("unexpected_valid", 1, 0);
          end else begin
            cur = exp_q.pop_front();
            check("latency", cyc, lat_q.pop_front());
          end
        end
        if (valid) begin
          check("data", data, cur);
          check("busy_out", busy, 1);
        end
        check("done", done, (cyc == done_at) ? 1 : 0);
        if (cyc == done_at) check("busy_done", busy, 0);
        if (valid && ready) done_at = cyc + 1;
      end
      prev = valid;
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ------------------------------------------------------------ stimulus
  initial begin
    rst = 1'b1; start = 1'b0; reuse_ker = 1'b0; relu = 1'b0; stride = '0;
    shift = '0; src_base = '0; ker_base = '0; ready = 1'b0;
    for (int k = 0; k < KK; k++) mk[k] = 0;
    for (int a = 0; a < 1024; a++) begin
      src_mem[a] = 8'(a);
      ker_mem[a] = 8'($urandom);
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_valid", valid, 0);
    check("rst_done", done, 0);
    check("rst_ker_rd", ker_rd, 0);
    check("rst_src_rd", src_rd, 0);
    check("rst_data", data, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Identity kernel at address 0, then reuse it with a long hold.
    for (int k = 0; k < KK; k++) ker_mem[k] = (k == KK/2) ? 8'd1 : 8'd0;
    do_run(0, 1, 1, 0, 0, 0, 0);
    do_run(1, 1, 1, 0, 0, 0, 5);

    // All-ones kernel over saturated pixels.
    for (int k = 0; k < KK; k++) ker_mem[200 + k] = 8'd1;
    for (int a = 0; a < 1024; a++) src_mem[a] = 8'd255;
    do_run(0, 1, 1, 0, 50, 200, 1);
    do_run(1, 0, 1, 0, 50, 200, 0);

    // Kernel of -1 over pixels of 10.
    for (int k = 0; k < KK; k++) ker_mem[300 + k] = 8'hFF;
    for (int a = 0; a < 1024; a++) src_mem[a] = 8'd10;
    do_run(0, 1, 1, 0, 7, 300, 0);
    do_run(1, 0, 1, 0, 7, 300, 2);
    do_run(1, 0, 1, 2, 7, 300, 0);

    // Stride 0 and address wrap with random contents.
    for (int a = 0; a < 1024; a++) src_mem[a] = 8'($urandom);
    do_run(0, 0, 0, 3, 1000, 1020, 1);

    // Random runs.
    for (int i = 0; i < 24; i++) begin
      for (int a = 0; a < 1024; a++) src_mem[a] = 8'($urandom);
      for (int a = 0; a < 1024; a++) ker_mem[a] = 8'($urandom);
      do_run(1'($urandom), 1'($urandom), $urandom_range(0, 7), $urandom_range(0, 15),
             $urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 4));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    // Reset mid-run clears the kernel: reused kernel then yields zeros.
    do_abort(300);
    do_run(1, 0, 1, 0, 0, 0, 0);
    do_run(1, 1, 2, 0, 500, 0, 1);

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
